// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage.
// Holds the opcode constants, the NOP encoding, the default reset PC,
// the fetch FSM state encoding and small helpers used by the fetch logic.
package fetch_stage_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;

  // sll $0,$0,0 -- architecturally a no-op, used as the IF/ID bubble
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // request outstanding (once out of reset)
    ST_HOLD    = 2'd1,  // instruction parked in skid buffer during stall
    ST_DISCARD = 2'd2   // waiting to swallow the response of a squashed request
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            capture instr_i/pc4_i and mark the entry valid
//   flush_i           replace the entry with a bubble (NOP, invalid); PC+4 kept
//   instr_i, pc4_i    incoming instruction and its PC+4
//   instr_o, pc4_o    registered instruction and PC+4
//   valid_o           entry holds a real instruction
// With neither load_i nor flush_i asserted the register holds. Flush wins.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage.
// Keeps the PC, issues one instruction-memory request at a time, parks a
// response that arrives during a stall in a skid buffer, squashes requests
// made stale by a taken branch, and feeds the IF/ID register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Stall                      hold PC and IF/ID
//   BranchTaken, BranchTarget  redirect (overrides Stall)
//   IMemReq, IMemAddr          memory request level and word-aligned address
//   IMemRdata, IMemValid       memory response, valid strobe one cycle
//   Instr_ID, PC4_ID, Valid_ID IF/ID contents
//   Opcode_ID                  Instr_ID[31:26]
//   FetchCount                 instructions delivered to IF/ID (wraps)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  input  logic        IMemValid,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC4_ID,
  output logic        Valid_ID,
  output logic [5:0]  Opcode_ID,
  output logic [31:0] FetchCount
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  cnt_q, cnt_d;
  // Low during reset and for the first cycle after it, so the first request
  // appears only after the first clock edge following reset release.
  logic         armed_q;

  logic         req_out;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = align_word(BranchTarget);
  assign req_out  = armed_q && (state_q == ST_FETCH);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = IMemRdata;

    unique case (state_q)
      ST_FETCH: begin
        if (BranchTaken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          // Response still to come: it must be swallowed before refetching.
          if (req_out && !IMemValid) state_d = ST_DISCARD;
        end else if (req_out && IMemValid) begin
          if (Stall) begin
            skid_d  = IMemRdata;
            state_d = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
            cnt_d     = cnt_q + 32'd1;
          end
        end else if (!Stall) begin
          ifid_flush = 1'b1;
        end
      end

      ST_HOLD: begin
        if (BranchTaken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          skid_d     = '0;
          state_d    = ST_FETCH;
        end else if (!Stall) begin
          ifid_instr = skid_q;
          ifid_load  = 1'b1;
          pc_d       = pc_plus4;
          cnt_d      = cnt_q + 32'd1;
          skid_d     = '0;
          state_d    = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        if (BranchTaken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
        end else if (!Stall) begin
          ifid_flush = 1'b1;
        end
        // The squashed response closes the outstanding request either way.
        if (IMemValid) state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr),
    .pc4_i   (pc_plus4),
    .instr_o (Instr_ID),
    .pc4_o   (PC4_ID),
    .valid_o (Valid_ID)
  );

  assign IMemReq    = req_out;
  assign IMemAddr   = pc_q;
  assign Opcode_ID  = opcode_of(Instr_ID);
  assign FetchCount = cnt_q;

endmodule
